// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if
//   Byte handshake between a producer and uart_transmitter.
//   DataIn   : byte to transmit (master -> slave)
//   Tx_valid : DataIn valid (master -> slave)
//   Tx_ready : transmitter idle and able to accept (slave -> master)
interface uart_transmitter_if;
  logic [7:0] DataIn;
  logic       Tx_valid;
  logic       Tx_ready;

  modport master (output DataIn, output Tx_valid, input  Tx_ready);
  modport slave  (input  DataIn, input  Tx_valid, output Tx_ready);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Serial UART transmitter: start bit, D0..D7 LSB first, parity, stop bit(s).
//   Shares the BC baud-select encoding of the companion receiver and honours
//   its Mreset resend request (abort frame, guard period, resend last byte).
// Ports:
//   clk      : system clock (50 MHz)
//   reset    : synchronous, active-high reset
//   BC       : baud select, clocks/bit 001=217 010=109 011=72 100=36 else 434
//   tx_if    : byte handshake (DataIn, Tx_valid, Tx_ready)
//   Mreset   : resend request from the receiver
//   Tx_out   : registered serial line, idles high
//   Tx_done  : one-cycle pulse in the first IDLE cycle after the last stop bit
module uart_transmitter #(
  parameter int unsigned STOP_BITS  = 1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           BC,
  uart_transmitter_if.slave    tx_if,
  input  logic                 Mreset,
  output logic                 Tx_out,
  output logic                 Tx_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GUARD
  } state_t;

  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  state_t     r_state, w_state_nxt;
  logic [8:0] r_cnt, w_cnt_nxt;
  logic [8:0] r_div, w_div_nxt;
  logic [2:0] r_bit_idx, w_bit_nxt;
  logic       r_stop_cnt, w_stop_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_have_byte, w_have_nxt;
  logic       r_tx_out, w_tx_nxt;
  logic       r_tx_done, w_done_nxt;
  logic       w_ready;
  logic [8:0] w_bc_div;
  logic       w_bit_end;
  logic       w_parity;

  always_comb begin
    case (BC)
      3'b001:  w_bc_div = 9'd217;
      3'b010:  w_bc_div = 9'd109;
      3'b011:  w_bc_div = 9'd72;
      3'b100:  w_bc_div = 9'd36;
      default: w_bc_div = 9'd434;
    endcase
  end

  assign w_bit_end = (r_cnt == (r_div - 9'd1));
  assign w_parity  = (^r_data) ^ PARITY_ODD;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div       <= 9'd434;
      r_bit_idx   <= '0;
      r_stop_cnt  <= 1'b0;
      r_data      <= '0;
      r_have_byte <= 1'b0;
      r_tx_out    <= 1'b1;
      r_tx_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div       <= w_div_nxt;
      r_bit_idx   <= w_bit_nxt;
      r_stop_cnt  <= w_stop_nxt;
      r_data      <= w_data_nxt;
      r_have_byte <= w_have_nxt;
      r_tx_out    <= w_tx_nxt;
      r_tx_done   <= w_done_nxt;
    end
  end

  // Tx_out is computed for the next state and registered with it, so the
  // line value always lines up with the state that owns it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit_idx;
    w_stop_nxt  = r_stop_cnt;
    w_data_nxt  = r_data;
    w_have_nxt  = r_have_byte;
    w_tx_nxt    = r_tx_out;
    w_done_nxt  = 1'b0;
    w_ready     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (Mreset && r_have_byte) begin
          // Resend request wins over a new byte; ready stays low this cycle.
          w_state_nxt = S_GUARD;
          w_cnt_nxt   = '0;
        end else begin
          w_ready = 1'b1;
          if (tx_if.Tx_valid) begin
            w_state_nxt = S_START;
            w_data_nxt  = tx_if.DataIn;
            w_div_nxt   = w_bc_div;
            w_have_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_tx_nxt    = 1'b0;
          end
        end
      end
      S_GUARD: begin
        w_tx_nxt = 1'b1;
        if (Mreset) begin
          w_cnt_nxt = '0;
        end else if (w_bit_end) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_tx_nxt    = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_data[0];
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_PARITY;
            w_tx_nxt    = w_parity;
          end else begin
            w_bit_nxt = r_bit_idx + 3'd1;
            w_tx_nxt  = r_data[r_bit_idx + 3'd1];
          end
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_cnt_nxt   = '0;
          w_stop_nxt  = 1'b0;
          w_tx_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_stop_cnt == LAST_STOP) begin
            w_state_nxt = S_IDLE;
            w_stop_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_stop_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // A resend request aborts any in-flight frame regardless of bit position.
    if (Mreset && (r_state inside {S_START, S_DATA, S_PARITY, S_STOP})) begin
      w_state_nxt = S_GUARD;
      w_cnt_nxt   = '0;
      w_bit_nxt   = '0;
      w_stop_nxt  = 1'b0;
      w_tx_nxt    = 1'b1;
      w_done_nxt  = 1'b0;
    end
  end

  assign tx_if.Tx_ready = w_ready;
  assign Tx_out         = r_tx_out;
  assign Tx_done        = r_tx_done;

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] BC;
  logic       Mreset;
  logic       Tx_out;
  logic       Tx_done;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_transmitter_if ifc ();

  uart_transmitter #(.STOP_BITS(1), .PARITY_ODD(1'b0)) dut (
    .clk     (clk),
    .reset   (reset),
    .BC      (BC),
    .tx_if   (ifc.slave),
    .Mreset  (Mreset),
    .Tx_out  (Tx_out),
    .Tx_done (Tx_done)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle Tx_valid from a negedge; returns in frame cycle 1
  // (the cycle after the accept edge).
  task automatic send(input logic [7:0] d, input logic [2:0] bc);
    ifc.DataIn   = d;
    BC           = bc;
    ifc.Tx_valid = 1'b1;
    @(negedge clk);
    ifc.Tx_valid = 1'b0;
  endtask

  // Sample one frame starting in frame cycle 1. bits[i] is the line value at
  // the first cycle of bit i; unstable counts cycles differing within a bit.
  // done_cyc is the frame cycle in which Tx_done is first seen (0 = never).
  // Returns at the negedge where Tx_done was seen (or after the bound).
  task automatic capture(input int unsigned div, input int unsigned nbits,
                         output logic [11:0] bits, output int unsigned unstable,
                         output int unsigned ready_hi, output int unsigned done_early,
                         output int unsigned done_cyc);
    int unsigned b;
    bits = '1; unstable = 0; ready_hi = 0; done_early = 0; done_cyc = 0;
    for (int unsigned c = 1; c <= div * nbits; c++) begin
      b = (c - 1) / div;
      if (((c - 1) % div) == 0) bits[b] = Tx_out;
      else if (Tx_out !== bits[b]) unstable++;
      if (ifc.Tx_ready === 1'b1) ready_hi++;
      if (Tx_done === 1'b1) done_early++;
      @(negedge clk);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      if (Tx_done === 1'b1) begin
        done_cyc = div * nbits + 1 + k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; Mreset = 1'b0; ifc.Tx_valid = 1'b0; ifc.DataIn = 8'h00; BC = 3'b000;
    repeat (3) @(negedge clk);
    tests_run++;
    if (Tx_out !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_out: got %b want 1", Tx_out); end
    tests_run++;
    if (ifc.Tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", ifc.Tx_ready); end
    tests_run++;
    if (Tx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", Tx_done); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_a5;
    logic [11:0] bits; int unsigned unst, rdy, early, dcyc;
    send(8'hA5, 3'b000);
    ifc.DataIn = 8'h00; BC = 3'b100;   // must be ignored mid-frame
    capture(434, 11, bits, unst, rdy, early, dcyc);
    tests_run++;
    if (bits !== {1'b1, 1'b1, 1'b0, 8'hA5, 1'b0}) begin tests_failed++; $display("FAIL a5_bits: got %b want %b", bits, {1'b1, 1'b1, 1'b0, 8'hA5, 1'b0}); end
    tests_run++;
    if (unst !== 0) begin tests_failed++; $display("FAIL a5_bit_width: got %0d unstable cycles want 0", unst); end
    tests_run++;
    if (rdy !== 0) begin tests_failed++; $display("FAIL a5_ready_low: got %0d ready cycles want 0", rdy); end
    tests_run++;
    if (early !== 0) begin tests_failed++; $display("FAIL a5_early_done: got %0d want 0", early); end
    // Tx_done rises 4774 clocks after the start edge -> frame cycle 4775.
    tests_run++;
    if (dcyc !== 4775) begin tests_failed++; $display("FAIL a5_done_cycle: got %0d want 4775", dcyc); end
    tests_run++;
    if (ifc.Tx_ready !== 1'b1) begin tests_failed++; $display("FAIL a5_ready_at_done: got %b want 1", ifc.Tx_ready); end
    @(negedge clk);
    tests_run++;
    if (Tx_done !== 1'b0) begin tests_failed++; $display("FAIL a5_done_pulse_width: got %b want 0", Tx_done); end
  endtask

  task automatic test_frame_07;
    logic [11:0] bits; int unsigned unst, rdy, early, dcyc;
    send(8'h07, 3'b100);
    capture(36, 11, bits, unst, rdy, early, dcyc);
    tests_run++;
    if (bits[8:1] !== 8'h07) begin tests_failed++; $display("FAIL 07_data: got %h want 07", bits[8:1]); end
    tests_run++;
    if (bits[9] !== 1'b1) begin tests_failed++; $display("FAIL 07_parity: got %b want 1", bits[9]); end
    tests_run++;
    if ({bits[10], bits[0]} !== 2'b10) begin tests_failed++; $display("FAIL 07_start_stop: got %b want 10", {bits[10], bits[0]}); end
    tests_run++;
    if (unst !== 0) begin tests_failed++; $display("FAIL 07_bit_width: got %0d want 0", unst); end
    tests_run++;
    if (dcyc !== 397) begin tests_failed++; $display("FAIL 07_done_cycle: got %0d want 397", dcyc); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [11:0] bits; int unsigned unst, rdy, early, dcyc;
    send(8'h00, 3'b011);
    capture(72, 11, bits, unst, rdy, early, dcyc);
    tests_run++;
    if (bits !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin tests_failed++; $display("FAIL b2b_first_bits: got %b want %b", bits, {1'b1, 1'b1, 1'b0, 8'h00, 1'b0}); end
    tests_run++;
    if (dcyc !== 793) begin tests_failed++; $display("FAIL b2b_first_done: got %0d want 793", dcyc); end
    tests_run++;
    if (ifc.Tx_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_in_done: got %b want 1", ifc.Tx_ready); end
    // Accept in the Tx_done cycle; capture starts the very next cycle.
    send(8'hFF, 3'b011);
    capture(72, 11, bits, unst, rdy, early, dcyc);
    tests_run++;
    if (bits !== {1'b1, 1'b1, 1'b0, 8'hFF, 1'b0}) begin tests_failed++; $display("FAIL b2b_second_bits: got %b want %b", bits, {1'b1, 1'b1, 1'b0, 8'hFF, 1'b0}); end
    tests_run++;
    if (unst !== 0 || rdy !== 0) begin tests_failed++; $display("FAIL b2b_second_frame: got unstable=%0d ready=%0d want 0/0", unst, rdy); end
    tests_run++;
    if (dcyc !== 793) begin tests_failed++; $display("FAIL b2b_second_done: got %0d want 793", dcyc); end
    @(negedge clk);
  endtask

  task automatic test_mreset;
    logic [11:0] bits; int unsigned unst, rdy, early, dcyc;
    int unsigned g_high, g_rdy, g_done;
    send(8'h3C, 3'b001);
    repeat (4 * 217 + 99) @(negedge clk);   // middle of D3
    tests_run++;
    if (Tx_out !== 1'b1) begin tests_failed++; $display("FAIL mr_d3_value: got %b want 1", Tx_out); end
    Mreset = 1'b1;
    @(negedge clk);
    Mreset = 1'b0;
    tests_run++;
    if (Tx_out !== 1'b1 || ifc.Tx_ready !== 1'b0 || Tx_done !== 1'b0) begin
      tests_failed++; $display("FAIL mr_abort: got out=%b ready=%b done=%b want 1/0/0", Tx_out, ifc.Tx_ready, Tx_done);
    end
    g_high = 0; g_rdy = 0; g_done = 0;
    for (int unsigned i = 0; i < 217; i++) begin
      if (Tx_out === 1'b1) g_high++;
      if (ifc.Tx_ready === 1'b1) g_rdy++;
      if (Tx_done === 1'b1) g_done++;
      @(negedge clk);
    end
    tests_run++;
    if (g_high !== 217 || g_rdy !== 0 || g_done !== 0) begin
      tests_failed++; $display("FAIL mr_guard: got high=%0d ready=%0d done=%0d want 217/0/0", g_high, g_rdy, g_done);
    end
    capture(217, 11, bits, unst, rdy, early, dcyc);
    tests_run++;
    if (bits !== {1'b1, 1'b1, 1'b0, 8'h3C, 1'b0}) begin tests_failed++; $display("FAIL mr_resend_bits: got %b want %b", bits, {1'b1, 1'b1, 1'b0, 8'h3C, 1'b0}); end
    tests_run++;
    if (dcyc !== 2388 || early !== 0) begin tests_failed++; $display("FAIL mr_resend_done: got cycle=%0d early=%0d want 2388/0", dcyc, early); end
    @(negedge clk);
    tests_run++;
    if (Tx_done !== 1'b0) begin tests_failed++; $display("FAIL mr_single_done: got %b want 0", Tx_done); end
  endtask

  task automatic test_reset_mid_data;
    int unsigned n_high, n_rdy, n_done;
    send(8'h81, 3'b100);
    repeat (2 * 36 + 9) @(negedge clk);     // inside D1 (a 0 bit)
    tests_run++;
    if (Tx_out !== 1'b0) begin tests_failed++; $display("FAIL rst_pre_d1: got %b want 0", Tx_out); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (Tx_out !== 1'b1 || ifc.Tx_ready !== 1'b1 || Tx_done !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_data: got out=%b ready=%b done=%b want 1/1/0", Tx_out, ifc.Tx_ready, Tx_done);
    end
    Mreset = 1'b1;
    #1;
    tests_run++;
    if (ifc.Tx_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mreset_ready: got %b want 1", ifc.Tx_ready); end
    @(negedge clk);
    Mreset = 1'b0;
    n_high = 0; n_rdy = 0; n_done = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (Tx_out === 1'b1) n_high++;
      if (ifc.Tx_ready === 1'b1) n_rdy++;
      if (Tx_done === 1'b1) n_done++;
      @(negedge clk);
    end
    tests_run++;
    if (n_high !== 40 || n_rdy !== 40 || n_done !== 0) begin
      tests_failed++; $display("FAIL rst_mreset_ignored: got high=%0d ready=%0d done=%0d want 40/40/0", n_high, n_rdy, n_done);
    end
  endtask

  task automatic test_valid_and_mreset_idle;
    logic [11:0] bits; int unsigned unst, rdy, early, dcyc;
    int unsigned g_high, g_rdy;
    send(8'h5A, 3'b100);
    capture(36, 11, bits, unst, rdy, early, dcyc);
    @(negedge clk);                          // idle, have_byte set
    ifc.DataIn = 8'hC3; ifc.Tx_valid = 1'b1; Mreset = 1'b1;
    #1;
    tests_run++;
    if (ifc.Tx_ready !== 1'b0) begin tests_failed++; $display("FAIL vm_ready_low: got %b want 0", ifc.Tx_ready); end
    repeat (3) @(negedge clk);               // Mreset held for three edges
    Mreset = 1'b0;
    g_high = 0; g_rdy = 0;
    for (int unsigned i = 0; i < 36; i++) begin
      if (Tx_out === 1'b1) g_high++;
      if (ifc.Tx_ready === 1'b1) g_rdy++;
      @(negedge clk);
    end
    tests_run++;
    if (g_high !== 36 || g_rdy !== 0) begin tests_failed++; $display("FAIL vm_guard: got high=%0d ready=%0d want 36/0", g_high, g_rdy); end
    capture(36, 11, bits, unst, rdy, early, dcyc);
    tests_run++;
    if (bits !== {1'b1, 1'b1, 1'b0, 8'h5A, 1'b0}) begin tests_failed++; $display("FAIL vm_resend_bits: got %b want %b", bits, {1'b1, 1'b1, 1'b0, 8'h5A, 1'b0}); end
    tests_run++;
    if (rdy !== 0 || dcyc !== 397) begin tests_failed++; $display("FAIL vm_resend_frame: got ready=%0d done=%0d want 0/397", rdy, dcyc); end
    // Tx_valid still high: C3 is taken at this Tx_done-cycle edge.
    @(negedge clk);
    ifc.Tx_valid = 1'b0;
    capture(36, 11, bits, unst, rdy, early, dcyc);
    tests_run++;
    if (bits !== {1'b1, 1'b1, 1'b0, 8'hC3, 1'b0}) begin tests_failed++; $display("FAIL vm_new_byte: got %b want %b", bits, {1'b1, 1'b1, 1'b0, 8'hC3, 1'b0}); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; Mreset = 1'b0; BC = 3'b000;
    ifc.Tx_valid = 1'b0; ifc.DataIn = 8'h00;
    @(negedge clk);
    test_reset();
    test_frame_a5();
    test_frame_07();
    test_back_to_back();
    test_mreset();
    test_reset_mid_data();
    test_valid_and_mreset_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
